// File: rtl/output_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : output_scheduler
//  Description : Per-output-port scheduler. Round-robin arbitration among four
//                input selectors, grant held for a full packet, flits paced
//                against downstream buffer credits.
//  Revision    : 1.0 - initial release
// ============================================================================
module output_scheduler #(
  parameter int PACKET_FLITS = 5,
  parameter int BUFFER_DEPTH = 4,
  parameter int CREDIT_WIDTH = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] request_vector_din,
  input  logic       credit_in_din,
  output logic [3:0] grant_vector_dout,
  output logic [3:0] transfer_strobe_dout,
  output logic       port_available_dout,
  output logic       flit_valid_dout
);

  localparam int                      c_CNT_W       = (PACKET_FLITS > 1) ? $clog2(PACKET_FLITS) : 1;
  localparam logic [c_CNT_W-1:0]      c_LAST_FLIT   = c_CNT_W'(PACKET_FLITS - 1);
  localparam logic [CREDIT_WIDTH-1:0] c_MAX_CREDITS = CREDIT_WIDTH'(BUFFER_DEPTH);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              grant_q, grant_d;
  logic [3:0]              strobe_q, strobe_d;
  logic [1:0]              rr_ptr_q, rr_ptr_d;
  logic [c_CNT_W-1:0]      flit_count_q, flit_count_d;
  logic [CREDIT_WIDTH-1:0] credits_q, credits_d;

  logic                    win_found;
  logic [1:0]              win_idx;
  logic [1:0]              cand_idx;
  logic [CREDIT_WIDTH:0]   credit_sum;

  // Outputs are taken straight from registers; flit_valid only decodes state and credits.
  assign grant_vector_dout    = grant_q;
  assign transfer_strobe_dout = strobe_q;
  assign port_available_dout  = (state_q == S_IDLE);
  assign flit_valid_dout      = (state_q == S_ACTIVE) && (credits_q != '0);

  // Round-robin search: first requester after the last winner, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int k = 1; k <= 4; k++) begin
      cand_idx = rr_ptr_q + 2'(k);
      if (!win_found && request_vector_din[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Credit bookkeeping runs in both states; overflow from a misbehaving downstream saturates.
  always_comb begin
    credit_sum = {1'b0, credits_q}
               - {{CREDIT_WIDTH{1'b0}}, flit_valid_dout}
               + {{CREDIT_WIDTH{1'b0}}, credit_in_din};
    if (credit_sum > {1'b0, c_MAX_CREDITS}) begin
      credits_d = c_MAX_CREDITS;
    end else begin
      credits_d = credit_sum[CREDIT_WIDTH-1:0];
    end
  end

  // Next-state logic: grant on a request in IDLE, release after the last flit of the packet.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    strobe_d     = '0;
    rr_ptr_d     = rr_ptr_q;
    flit_count_d = flit_count_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d      = S_ACTIVE;
          grant_d      = 4'b0001 << win_idx;
          strobe_d     = 4'b0001 << win_idx;
          rr_ptr_d     = win_idx;
          flit_count_d = '0;
        end
      end
      S_ACTIVE: begin
        if (flit_valid_dout) begin
          if (flit_count_q == c_LAST_FLIT) begin
            state_d      = S_IDLE;
            grant_d      = '0;
            flit_count_d = '0;
          end else begin
            flit_count_d = flit_count_q + c_CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers; reset aborts any packet in flight and refills the credit pool.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      strobe_q     <= '0;
      rr_ptr_q     <= 2'd3;
      flit_count_q <= '0;
      credits_q    <= c_MAX_CREDITS;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      strobe_q     <= strobe_d;
      rr_ptr_q     <= rr_ptr_d;
      flit_count_q <= flit_count_d;
      credits_q    <= credits_d;
    end
  end

`ifndef SYNTHESIS
  // A credit returned while the pool is already full (and nothing is sent) is a downstream bug.
  a_credit_overflow : assert property (@(posedge clk) disable iff (!reset)
    !(credit_in_din && !flit_valid_dout && (credits_q == c_MAX_CREDITS)))
    else $error("output_scheduler: credit return above buffer depth");
`endif

endmodule
`default_nettype wire
